// File: rtl/bingo_pkg.sv
// Shared defaults and phase encoding for the Bingo turn controller.
package bingo_pkg;

  localparam int unsigned DEFAULT_N         = 5;
  localparam int unsigned DEFAULT_NUM_W     = 5;
  localparam int unsigned DEFAULT_WIN_LINES = 5;
  localparam int unsigned LINES_W           = 4;

  typedef enum logic [1:0] {
    PH_SETUP  = 2'd0,
    PH_LOCAL  = 2'd1,
    PH_REMOTE = 2'd2,
    PH_DONE   = 2'd3
  } phase_e;

endpackage

// File: rtl/bingo_line_counter.sv
// Counts fully marked rows, columns and both diagonals of the board; registered output.
module bingo_line_counter
  import bingo_pkg::*;
#(
  parameter int unsigned N = DEFAULT_N
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N*N-1:0]     marked_i,
  output logic [LINES_W-1:0] lines_o
);

  logic [LINES_W-1:0] lines_d;
  logic [LINES_W-1:0] lines_q;
  logic               row_full;
  logic               col_full;
  logic               diag_full;
  logic               anti_full;

  // Evaluate every row/column pair in one pass, diagonals accumulated alongside.
  always_comb begin
    lines_d   = '0;
    row_full  = 1'b1;
    col_full  = 1'b1;
    diag_full = 1'b1;
    anti_full = 1'b1;
    for (int unsigned r = 0; r < N; r++) begin
      row_full = 1'b1;
      col_full = 1'b1;
      for (int unsigned c = 0; c < N; c++) begin
        row_full &= marked_i[r*N + c];
        col_full &= marked_i[c*N + r];
      end
      lines_d   = lines_d + LINES_W'(row_full) + LINES_W'(col_full);
      diag_full &= marked_i[r*N + r];
      anti_full &= marked_i[r*N + (N - 1 - r)];
    end
    lines_d = lines_d + LINES_W'(diag_full) + LINES_W'(anti_full);
  end

  // Register the count so it lags the marked bitmap by one cycle.
  always_ff @(posedge clk) begin
    if (rst) lines_q <= '0;
    else     lines_q <= lines_d;
  end

  assign lines_o = lines_q;

endmodule

// File: rtl/bingo_turn_ctrl.sv
// Bingo game sequencer: keypad entry, board fill, turn alternation, marking and win detection.
module bingo_turn_ctrl
  import bingo_pkg::*;
#(
  parameter int unsigned N         = DEFAULT_N,
  parameter int unsigned NUM_W     = DEFAULT_NUM_W,
  parameter int unsigned WIN_LINES = DEFAULT_WIN_LINES
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               digit_valid,
  input  logic [3:0]         digit,
  input  logic               enter_pulse,
  input  logic               clear_pulse,
  input  logic               local_first,
  input  logic               remote_valid,
  input  logic [NUM_W-1:0]   remote_num,
  output logic               cell_wr_en,
  output logic [NUM_W-1:0]   cell_wr_idx,
  output logic [NUM_W-1:0]   cell_wr_val,
  output logic [6:0]         entry,
  output logic [1:0]         phase,
  output logic               call_valid,
  output logic [NUM_W-1:0]   call_num,
  output logic               err,
  output logic [N*N-1:0]     marked,
  output logic [3:0]         lines,
  output logic               win
);

  localparam logic [6:0]         CELLS_E  = 7'(N*N);
  localparam logic [NUM_W-1:0]   CELLS_N  = NUM_W'(N*N);
  localparam logic [NUM_W-1:0]   LAST_IDX = NUM_W'(N*N - 1);
  localparam logic [LINES_W-1:0] WIN_L    = LINES_W'(WIN_LINES);

  phase_e               phase_q;
  logic [6:0]           entry_q;
  logic [1:0]           cnt_q;
  logic [NUM_W-1:0]     fill_q;
  logic [NUM_W-1:0]     board_q [N*N];
  logic [2**NUM_W-1:0]  used_q;
  logic [2**NUM_W-1:0]  called_q;
  logic [N*N-1:0]       marked_q;
  logic                 wr_en_q;
  logic [NUM_W-1:0]     wr_idx_q;
  logic [NUM_W-1:0]     wr_val_q;
  logic                 call_valid_q;
  logic [NUM_W-1:0]     call_num_q;
  logic                 err_q;
  logic                 win_q;
  logic [LINES_W-1:0]   lines_w;

  logic [NUM_W-1:0]     entry_idx;
  logic                 keypad_ok;
  logic                 win_hit;
  logic                 in_range;
  logic                 commit;
  logic                 setup_acc;
  logic                 local_acc;
  logic                 remote_ok;
  logic                 remote_acc;
  logic                 remote_rej;
  logic                 digit_acc;

  assign entry_idx = entry_q[NUM_W-1:0];

  // Decode this cycle's accept/reject decisions; a pending win overrides all inputs.
  always_comb begin
    keypad_ok  = (phase_q == PH_SETUP) || (phase_q == PH_LOCAL);
    win_hit    = ((phase_q == PH_LOCAL) || (phase_q == PH_REMOTE)) && (lines_w >= WIN_L);
    in_range   = (cnt_q != 2'd0) && (entry_q >= 7'd1) && (entry_q <= CELLS_E);
    commit     = keypad_ok && enter_pulse && !clear_pulse && !win_hit;
    setup_acc  = commit && (phase_q == PH_SETUP) && in_range && !used_q[entry_idx];
    local_acc  = commit && (phase_q == PH_LOCAL) && in_range && !called_q[entry_idx];
    remote_ok  = (remote_num != '0) && (remote_num <= CELLS_N) && !called_q[remote_num];
    remote_acc = (phase_q == PH_REMOTE) && remote_valid && !win_hit && remote_ok;
    remote_rej = (phase_q == PH_REMOTE) && remote_valid && !win_hit && !remote_ok;
    digit_acc  = keypad_ok && digit_valid && (digit <= 4'd9) &&
                 !enter_pulse && !clear_pulse && !win_hit;
  end

  // Game state machine with registered strobes; entry clears on any commit or phase change.
  always_ff @(posedge clk) begin
    if (rst) begin
      phase_q      <= PH_SETUP;
      entry_q      <= '0;
      cnt_q        <= '0;
      fill_q       <= '0;
      used_q       <= '0;
      called_q     <= '0;
      wr_en_q      <= 1'b0;
      wr_idx_q     <= '0;
      wr_val_q     <= '0;
      call_valid_q <= 1'b0;
      call_num_q   <= '0;
      err_q        <= 1'b0;
      win_q        <= 1'b0;
      for (int unsigned i = 0; i < N*N; i++) board_q[i] <= '0;
    end else begin
      wr_en_q      <= 1'b0;
      call_valid_q <= 1'b0;
      err_q        <= 1'b0;
      if (win_hit) begin
        phase_q <= PH_DONE;
        win_q   <= 1'b1;
        entry_q <= '0;
        cnt_q   <= '0;
      end else begin
        if ((keypad_ok && clear_pulse) || commit) begin
          entry_q <= '0;
          cnt_q   <= '0;
        end else if (digit_acc) begin
          entry_q <= (entry_q % 7'd10) * 7'd10 + {3'b000, digit};
          cnt_q   <= (cnt_q == 2'd2) ? 2'd2 : cnt_q + 2'd1;
        end
        if (setup_acc) begin
          board_q[fill_q]   <= entry_idx;
          used_q[entry_idx] <= 1'b1;
          wr_en_q           <= 1'b1;
          wr_idx_q          <= fill_q;
          wr_val_q          <= entry_idx;
          fill_q            <= fill_q + NUM_W'(1);
          if (fill_q == LAST_IDX) phase_q <= local_first ? PH_LOCAL : PH_REMOTE;
        end else if (local_acc) begin
          called_q[entry_idx] <= 1'b1;
          call_valid_q        <= 1'b1;
          call_num_q          <= entry_idx;
          phase_q             <= PH_REMOTE;
        end else if (commit) begin
          err_q <= 1'b1;
        end
        if (remote_acc) begin
          called_q[remote_num] <= 1'b1;
          phase_q              <= PH_LOCAL;
        end
        if (remote_rej) err_q <= 1'b1;
      end
    end
  end

  // A cell is marked once its stored value has been called; lags called by one cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      marked_q <= '0;
    end else begin
      for (int unsigned i = 0; i < N*N; i++) marked_q[i] <= called_q[board_q[i]];
    end
  end

  bingo_line_counter #(
    .N (N)
  ) u_line_counter (
    .clk      (clk),
    .rst      (rst),
    .marked_i (marked_q),
    .lines_o  (lines_w)
  );

  assign cell_wr_en  = wr_en_q;
  assign cell_wr_idx = wr_idx_q;
  assign cell_wr_val = wr_val_q;
  assign entry       = entry_q;
  assign phase       = phase_q;
  assign call_valid  = call_valid_q;
  assign call_num    = call_num_q;
  assign err         = err_q;
  assign marked      = marked_q;
  assign lines       = lines_w;
  assign win         = win_q;

endmodule

// File: tb/tb_bingo_turn_ctrl.sv
// Self-checking bench for bingo_turn_ctrl: vector table, directed game sequences, randomized games.
module tb_bingo_turn_ctrl;

  localparam int BN  = 5;
  localparam int BW  = 5;
  localparam int NN  = BN * BN;
  localparam int WIN = 5;

  logic          clk = 1'b0;
  logic          rst, digit_valid, enter_pulse, clear_pulse, local_first, remote_valid;
  logic [3:0]    digit;
  logic [BW-1:0] remote_num;
  logic          cell_wr_en, call_valid, err, win;
  logic [BW-1:0] cell_wr_idx, cell_wr_val, call_num;
  logic [6:0]    entry;
  logic [1:0]    phase;
  logic [NN-1:0] marked;
  logic [3:0]    lines;

  always #5 clk = ~clk;

  bingo_turn_ctrl #(.N(BN), .NUM_W(BW), .WIN_LINES(WIN)) dut (
    .clk(clk), .rst(rst), .digit_valid(digit_valid), .digit(digit),
    .enter_pulse(enter_pulse), .clear_pulse(clear_pulse), .local_first(local_first),
    .remote_valid(remote_valid), .remote_num(remote_num),
    .cell_wr_en(cell_wr_en), .cell_wr_idx(cell_wr_idx), .cell_wr_val(cell_wr_val),
    .entry(entry), .phase(phase), .call_valid(call_valid), .call_num(call_num),
    .err(err), .marked(marked), .lines(lines), .win(win)
  );

  int n_cmp = 0;
  int n_fail = 0;

  // Game-level reference: phase 0 SETUP, 1 LOCAL, 2 REMOTE, 3 DONE.
  int m_entry, m_cnt, m_phase, m_fill, m_lines, m_wr_idx, m_wr_val, m_call;
  int m_board [NN];
  bit m_used [NN+1];
  bit m_called [NN+1];
  bit m_marked [NN];
  bit m_wr, m_err, m_cv;

  function automatic int count_lines();
    int n = 0;
    bit d = 1, a = 1, rf, cf;
    for (int r = 0; r < BN; r++) begin
      rf = 1; cf = 1;
      for (int c = 0; c < BN; c++) begin
        rf &= m_marked[r*BN + c];
        cf &= m_marked[c*BN + r];
      end
      n += int'(rf) + int'(cf);
      d &= m_marked[r*BN + r];
      a &= m_marked[r*BN + BN - 1 - r];
    end
    return n + int'(d) + int'(a);
  endfunction

  task automatic model_step();
    bit nm [NN];
    int nl;
    bit ok;
    if (rst) begin
      m_entry = 0; m_cnt = 0; m_phase = 0; m_fill = 0; m_lines = 0;
      m_wr = 0; m_err = 0; m_cv = 0;
      for (int i = 0; i < NN; i++) begin m_board[i] = 0; m_marked[i] = 0; end
      for (int i = 0; i <= NN; i++) begin m_used[i] = 0; m_called[i] = 0; end
      return;
    end
    nl = count_lines();
    for (int i = 0; i < NN; i++) nm[i] = m_called[m_board[i]];
    m_wr = 0; m_cv = 0; m_err = 0;
    if ((m_phase == 1 || m_phase == 2) && m_lines >= WIN) begin
      m_phase = 3; m_entry = 0; m_cnt = 0;
    end else if (m_phase <= 1) begin
      if (clear_pulse) begin
        m_entry = 0; m_cnt = 0;
      end else if (enter_pulse) begin
        ok = (m_cnt > 0) && (m_entry >= 1) && (m_entry <= NN);
        if (ok) ok = (m_phase == 0) ? !m_used[m_entry] : !m_called[m_entry];
        if (!ok) m_err = 1;
        else if (m_phase == 0) begin
          m_board[m_fill] = m_entry; m_used[m_entry] = 1;
          m_wr = 1; m_wr_idx = m_fill; m_wr_val = m_entry;
          m_fill++;
          if (m_fill == NN) m_phase = local_first ? 1 : 2;
        end else begin
          m_called[m_entry] = 1; m_cv = 1; m_call = m_entry; m_phase = 2;
        end
        m_entry = 0; m_cnt = 0;
      end else if (digit_valid && digit <= 9) begin
        m_entry = (m_entry % 10) * 10 + int'(digit);
        m_cnt = (m_cnt < 2) ? m_cnt + 1 : 2;
      end
    end else if (m_phase == 2 && remote_valid) begin
      if (remote_num >= 1 && remote_num <= NN && !m_called[remote_num]) begin
        m_called[remote_num] = 1; m_phase = 1;
      end else m_err = 1;
    end
    m_marked = nm;
    m_lines = nl;
  endtask

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic compare_all();
    logic [NN-1:0] mv;
    for (int i = 0; i < NN; i++) mv[i] = m_marked[i];
    chk("phase", 32'(phase), m_phase);
    chk("entry", 32'(entry), m_entry);
    chk("cell_wr_en", 32'(cell_wr_en), 32'(m_wr));
    if (m_wr) begin
      chk("cell_wr_idx", 32'(cell_wr_idx), m_wr_idx);
      chk("cell_wr_val", 32'(cell_wr_val), m_wr_val);
    end
    chk("call_valid", 32'(call_valid), 32'(m_cv));
    if (m_cv) chk("call_num", 32'(call_num), m_call);
    chk("err", 32'(err), 32'(m_err));
    chk("marked", 32'(marked), 32'(mv));
    chk("lines", 32'(lines), m_lines);
    chk("win", 32'(win), 32'(m_phase == 3));
  endtask

  task automatic step(bit dv, int dg, bit en, bit cl, bit rv, int rn);
    digit_valid = dv; digit = 4'(dg); enter_pulse = en; clear_pulse = cl;
    remote_valid = rv; remote_num = BW'(rn);
    @(posedge clk);
    model_step();
    #1;
    compare_all();
    digit_valid = 0; enter_pulse = 0; clear_pulse = 0; remote_valid = 0;
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0);
  endtask
  task automatic press(int d);   step(1, d, 0, 0, 0, 0); endtask
  task automatic enter();        step(0, 0, 1, 0, 0, 0); endtask
  task automatic remote(int v);  step(0, 0, 0, 0, 1, v); endtask
  task automatic type_num(int v); press(v / 10); press(v % 10); enter(); endtask
  task automatic do_reset();     rst = 1; idle(1); rst = 0; endtask

  task automatic junk();
    step(bit'($urandom_range(0, 1)), int'($urandom_range(0, 15)), ($urandom_range(0, 3) == 0),
         ($urandom_range(0, 5) == 0), bit'($urandom_range(0, 1)), int'($urandom_range(0, 31)));
  endtask

  function automatic int pick(bit play);
    int q[$];
    for (int v = 1; v <= NN; v++)
      if (!(play ? m_called[v] : m_used[v])) q.push_back(v);
    if (q.size() == 0) return 0;
    return q[$urandom_range(0, q.size() - 1)];
  endfunction

  typedef struct {
    bit dv; int dg; bit en; bit cl;
    int x_entry; bit x_wr; bit x_err; int x_val;
  } vec_t;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    vec_t tbl[$];
    int guard;
    rst = 1; digit_valid = 0; digit = 0; enter_pulse = 0; clear_pulse = 0;
    local_first = 1; remote_valid = 0; remote_num = 0;

    // Entry / SETUP commit vectors from a fresh reset.
    tbl.push_back('{1, 1, 0, 0,  1, 0, 0, 0});
    tbl.push_back('{1, 2, 0, 0, 12, 0, 0, 0});
    tbl.push_back('{0, 0, 1, 0,  0, 1, 0, 12});
    tbl.push_back('{1, 1, 0, 0,  1, 0, 0, 0});
    tbl.push_back('{1, 2, 0, 0, 12, 0, 0, 0});
    tbl.push_back('{1, 3, 0, 0, 23, 0, 0, 0});
    tbl.push_back('{0, 0, 0, 1,  0, 0, 0, 0});
    tbl.push_back('{1, 2, 0, 0,  2, 0, 0, 0});
    tbl.push_back('{1, 6, 0, 0, 26, 0, 0, 0});
    tbl.push_back('{0, 0, 1, 0,  0, 0, 1, 0});
    tbl.push_back('{1, 1, 0, 0,  1, 0, 0, 0});
    tbl.push_back('{1, 2, 0, 0, 12, 0, 0, 0});
    tbl.push_back('{0, 0, 1, 0,  0, 0, 1, 0});
    tbl.push_back('{1, 3, 0, 0,  3, 0, 0, 0});
    tbl.push_back('{1, 5, 1, 0,  0, 1, 0, 3});
    tbl.push_back('{1, 4, 0, 0,  4, 0, 0, 0});
    tbl.push_back('{0, 0, 1, 1,  0, 0, 0, 0});
    tbl.push_back('{1, 12, 0, 0, 0, 0, 0, 0});
    tbl.push_back('{0, 0, 1, 0,  0, 0, 1, 0});
    tbl.push_back('{1, 0, 0, 0,  0, 0, 0, 0});
    tbl.push_back('{0, 0, 1, 0,  0, 0, 1, 0});
    tbl.push_back('{1, 0, 0, 0,  0, 0, 0, 0});
    tbl.push_back('{1, 5, 0, 0,  5, 0, 0, 0});
    tbl.push_back('{0, 0, 1, 0,  0, 1, 0, 5});
    tbl.push_back('{1, 9, 0, 0,  9, 0, 0, 0});
    tbl.push_back('{1, 9, 0, 0, 99, 0, 0, 0});
    tbl.push_back('{1, 4, 0, 0, 94, 0, 0, 0});
    tbl.push_back('{0, 0, 1, 0,  0, 0, 1, 0});

    do_reset();
    chk("rst_phase", 32'(phase), 0);
    chk("rst_entry", 32'(entry), 0);
    chk("rst_marked", 32'(marked), 0);
    chk("rst_lines", 32'(lines), 0);
    chk("rst_strobes", {29'd0, cell_wr_en, call_valid, err}, 0);
    chk("rst_win", 32'(win), 0);

    foreach (tbl[i]) begin
      step(tbl[i].dv, tbl[i].dg, tbl[i].en, tbl[i].cl, 0, 0);
      chk($sformatf("tbl%0d_entry", i), 32'(entry), tbl[i].x_entry);
      chk($sformatf("tbl%0d_wr", i), 32'(cell_wr_en), 32'(tbl[i].x_wr));
      chk($sformatf("tbl%0d_err", i), 32'(err), 32'(tbl[i].x_err));
      chk($sformatf("tbl%0d_phase", i), 32'(phase), 0);
      if (tbl[i].x_wr) chk($sformatf("tbl%0d_val", i), 32'(cell_wr_val), tbl[i].x_val);
    end

    // Ordered fill, remote player first; remote_valid must be ignored during SETUP.
    do_reset();
    local_first = 0;
    remote(3);
    chk("setup_remote_ignored", {30'd0, err, phase[0]}, 0);
    for (int v = 1; v <= NN; v++) type_num(v);
    chk("fill_remote_first", 32'(phase), 2);
    chk("last_wr_idx", 32'(cell_wr_idx), NN - 1);

    // Ordered fill, local player first, then a short exchange of calls.
    do_reset();
    local_first = 1;
    for (int v = 1; v <= NN; v++) type_num(v);
    chk("fill_local_first", 32'(phase), 1);
    press(7); enter();
    chk("call7_valid", 32'(call_valid), 1);
    chk("call7_num", 32'(call_num), 7);
    chk("call7_phase", 32'(phase), 2);
    idle(1);
    chk("marked6", 32'(marked[6]), 1);
    remote(7);
    chk("remote_dup_err", 32'(err), 1);
    chk("remote_dup_phase", 32'(phase), 2);
    remote(30);
    chk("remote_range_err", 32'(err), 1);
    remote(8);
    chk("remote8_phase", 32'(phase), 1);
    chk("remote8_err", 32'(err), 0);

    // Play the remaining numbers in order until the game ends.
    for (int v = 1; v <= NN && m_phase != 3; v++) begin
      if (m_called[v]) continue;
      if (m_phase == 1) type_num(v);
      else remote(v);
    end
    guard = 0;
    while (m_phase != 3 && guard < 8) begin idle(1); guard++; end
    chk("win_phase", 32'(phase), 3);
    chk("win_flag", 32'(win), 1);
    chk("win_lines", 32'(lines >= 4'(WIN)), 1);
    press(1); press(2); enter(); remote(9);
    chk("done_ignores_phase", 32'(phase), 3);
    chk("done_ignores_entry", 32'(entry), 0);
    chk("done_ignores_err", 32'(err), 0);
    do_reset();
    chk("rerst_phase", 32'(phase), 0);
    chk("rerst_marked", 32'(marked), 0);
    chk("rerst_win", 32'(win), 0);
    type_num(12);
    chk("rerst_used_clear", 32'(cell_wr_en), 1);

    // Randomized games with shuffled boards and interleaved junk input.
    for (int g = 0; g < 6; g++) begin
      do_reset();
      local_first = bit'($urandom_range(0, 1));
      guard = 0;
      while (m_phase == 0 && guard < 400) begin
        if ($urandom_range(0, 3) == 0) junk();
        else type_num(pick(0));
        guard++;
      end
      chk("rand_fill_done", 32'(phase != 2'd0), 1);
      guard = 0;
      while (m_phase != 3 && guard < 600) begin
        if ($urandom_range(0, 3) == 0) junk();
        else if (m_phase == 1) type_num(pick(1));
        else remote(pick(1));
        guard++;
      end
      idle(2);
      chk("rand_game_done", 32'(phase), 3);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
